// File: rtl/input_cond_pkg.sv
// Shared constants for the input conditioner: default 50 MHz timing values,
// auto-repeat state encodings and a counter-width helper.
package input_cond_pkg;

    // Default timing at 50 MHz
    localparam int DEB_10MS   = 500000;
    localparam int HOLD_500MS = 25000000;
    localparam int RPT_100MS  = 5000000;

    // Auto-repeat sequencer states
    localparam logic [1:0] RPT_IDLE = 2'd0;
    localparam logic [1:0] RPT_HOLD = 2'd1;
    localparam logic [1:0] RPT_RPT  = 2'd2;

    // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input: two-flop synchroniser, optional polarity inversion,
// debounce counter and single-cycle rise/fall pulses on the debounced level.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_10MS,
    parameter bit RESET_LVL  = 1'b0,
    parameter bit INVERT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = cnt_width(DEB_CYCLES, 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_q;
    logic [CW-1:0] r_cnt;
    logic          w_sample;

    // Metastability guard; resets to the pin's idle level so release of reset is quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RESET_LVL;
            r_sync2 <= RESET_LVL;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity so 1 always means active after this point
    assign w_sample = r_sync2 ^ INVERT;

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (w_sample == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_LAST) begin
            r_stable <= w_sample;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle-delayed copy of the debounced level for edge detection
    always_ff @(posedge clk) begin
        if (rst) r_stable_q <= 1'b0;
        else     r_stable_q <= r_stable;
    end

    assign o_level = r_stable;
    assign o_rise  = r_stable & ~r_stable_q;
    assign o_fall  = ~r_stable & r_stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel switch/button front end: per-pin debounce with edge pulses and
// a per-key auto-repeat sequencer (press, first repeat after hold, then periodic).
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_SW           = 10,
    parameter int N_KEY          = 4,
    parameter int DEB_CYCLES     = DEB_10MS,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int REPEAT_EN      = 1,
    parameter int HOLD_CYCLES    = HOLD_500MS,
    parameter int REPEAT_CYCLES  = RPT_100MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  SW,
    input  logic [N_KEY-1:0] KEY,
    output logic [N_SW-1:0]  SW_deb,
    output logic [N_SW-1:0]  SW_changed,
    output logic [N_KEY-1:0] KEY_down,
    output logic [N_KEY-1:0] KEY_pressed,
    output logic [N_KEY-1:0] KEY_released,
    output logic [N_KEY-1:0] KEY_repeat
);

    localparam int             RCW       = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [RCW-1:0] HOLD_LAST = RCW'(HOLD_CYCLES - 1);
    localparam logic [RCW-1:0] RPT_LAST  = RCW'(REPEAT_CYCLES - 1);
    localparam bit             KEY_INV   = (KEY_ACTIVE_LOW != 0);

    logic [N_SW-1:0] w_sw_rise;
    logic [N_SW-1:0] w_sw_fall;

    // Slide switches: idle low, no inversion; any toggle reports a change
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .RESET_LVL  (1'b0),
            .INVERT     (1'b0)
        ) u_sw (
            .clk     (clk),
            .rst     (rst),
            .i_pin   (SW[i]),
            .o_level (SW_deb[i]),
            .o_rise  (w_sw_rise[i]),
            .o_fall  (w_sw_fall[i])
        );
    end

    assign SW_changed = w_sw_rise | w_sw_fall;

    // Push-buttons: idle at the released pin level, normalised to 1 = pressed
    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .RESET_LVL  (KEY_INV),
            .INVERT     (KEY_INV)
        ) u_key (
            .clk     (clk),
            .rst     (rst),
            .i_pin   (KEY[k]),
            .o_level (KEY_down[k]),
            .o_rise  (KEY_pressed[k]),
            .o_fall  (KEY_released[k])
        );

        if (REPEAT_EN != 0) begin : g_rpt
            logic [1:0]     r_state;
            logic [RCW-1:0] r_rcnt;
            logic           w_term;

            // Terminal count of whichever timing phase the key is in
            always_comb begin
                w_term = 1'b0;
                case (r_state)
                    RPT_HOLD: w_term = (r_rcnt == HOLD_LAST);
                    RPT_RPT:  w_term = (r_rcnt == RPT_LAST);
                    default:  w_term = 1'b0;
                endcase
            end

            // Press fires immediately; release always wins over a coincident terminal count
            assign KEY_repeat[k] = (r_state == RPT_IDLE) ? KEY_pressed[k]
                                                         : (KEY_down[k] & w_term);

            // Hold/repeat sequencer: counter clears at every terminal count so it never wraps
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= RPT_IDLE;
                    r_rcnt  <= '0;
                end else if (!KEY_down[k]) begin
                    r_state <= RPT_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    case (r_state)
                        RPT_IDLE: begin
                            if (KEY_pressed[k]) begin
                                r_state <= RPT_HOLD;
                                r_rcnt  <= '0;
                            end
                        end
                        RPT_HOLD: begin
                            if (w_term) begin
                                r_state <= RPT_RPT;
                                r_rcnt  <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + 1'b1;
                            end
                        end
                        RPT_RPT: begin
                            if (w_term) r_rcnt <= '0;
                            else        r_rcnt <= r_rcnt + 1'b1;
                        end
                        default: begin
                            r_state <= RPT_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_norpt
            assign KEY_repeat[k] = KEY_pressed[k];
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a window-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_input_conditioner;

    localparam int N_SW  = 10;
    localparam int N_KEY = 4;
    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int REP   = 3;
    localparam int NCH   = N_SW + N_KEY;
    localparam int HL    = DEB + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_SW-1:0]  SW  = '0;
    logic [N_KEY-1:0] KEY = '1;

    logic [N_SW-1:0]  SW_deb, SW_changed;
    logic [N_KEY-1:0] KEY_down, KEY_pressed, KEY_released, KEY_repeat;
    logic [N_SW-1:0]  b_SW_deb, b_SW_changed;
    logic [N_KEY-1:0] b_KEY_down, b_KEY_pressed, b_KEY_released, b_KEY_repeat;

    input_conditioner #(
        .N_SW(N_SW), .N_KEY(N_KEY), .DEB_CYCLES(DEB), .KEY_ACTIVE_LOW(1),
        .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .SW(SW), .KEY(KEY),
        .SW_deb(SW_deb), .SW_changed(SW_changed), .KEY_down(KEY_down),
        .KEY_pressed(KEY_pressed), .KEY_released(KEY_released), .KEY_repeat(KEY_repeat)
    );

    input_conditioner #(
        .N_SW(N_SW), .N_KEY(N_KEY), .DEB_CYCLES(DEB), .KEY_ACTIVE_LOW(1),
        .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut_norpt (
        .clk(clk), .rst(rst), .SW(SW), .KEY(KEY),
        .SW_deb(b_SW_deb), .SW_changed(b_SW_changed), .KEY_down(b_KEY_down),
        .KEY_pressed(b_KEY_pressed), .KEY_released(b_KEY_released), .KEY_repeat(b_KEY_repeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_ph[c][k]: normalised pin level sampled k edges ago. A debounced level
    // flips once the DEB samples seen through the 2-edge synchroniser all
    // disagree with it. Repeats are scheduled from the press edge number.
    logic m_ph [NCH][HL];
    logic m_stable [NCH];
    logic m_prev [NCH];
    logic m_rep [N_KEY];
    int   m_tp [N_KEY];
    int   m_edge = 0;
    bit   m_init = 1'b0;

    function automatic logic pin_level(input int c);
        if (c < N_SW) return SW[c];
        return ~KEY[c - N_SW];
    endfunction

    task automatic model_step();
        bit settled;
        int c;
        int d;
        m_edge++;
        if (rst) m_init = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (rst) begin
                for (int k = 0; k < HL; k++) m_ph[ch][k] = 1'b0;
                m_stable[ch] = 1'b0;
                m_prev[ch]   = 1'b0;
            end else begin
                m_prev[ch] = m_stable[ch];
                for (int k = HL - 1; k > 0; k--) m_ph[ch][k] = m_ph[ch][k-1];
                m_ph[ch][0] = pin_level(ch);
                settled = 1'b1;
                for (int k = 2; k < HL; k++)
                    if (m_ph[ch][k] == m_stable[ch]) settled = 1'b0;
                if (settled) m_stable[ch] = ~m_stable[ch];
            end
        end
        for (int k = 0; k < N_KEY; k++) begin
            c = N_SW + k;
            if (rst) begin
                m_rep[k] = 1'b0;
                m_tp[k]  = 0;
            end else begin
                if (m_stable[c] && !m_prev[c]) m_tp[k] = m_edge;
                d = m_edge - m_tp[k];
                m_rep[k] = m_stable[c] &&
                           (d == 0 || d == HOLD || (d > HOLD && ((d - HOLD) % REP) == 0));
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model
    initial begin
        logic [N_SW-1:0]  e_swdeb, e_swch;
        logic [N_KEY-1:0] e_dn, e_pr, e_rl, e_rp;
        forever begin
            @(negedge clk);
            if (m_init) begin
                for (int c = 0; c < N_SW; c++) begin
                    e_swdeb[c] = m_stable[c];
                    e_swch[c]  = m_stable[c] ^ m_prev[c];
                end
                for (int k = 0; k < N_KEY; k++) begin
                    e_dn[k] = m_stable[N_SW+k];
                    e_pr[k] = m_stable[N_SW+k] & ~m_prev[N_SW+k];
                    e_rl[k] = ~m_stable[N_SW+k] & m_prev[N_SW+k];
                    e_rp[k] = m_rep[k];
                end
                check("SW_deb", SW_deb, e_swdeb);
                check("SW_changed", SW_changed, e_swch);
                check("KEY_down", KEY_down, e_dn);
                check("KEY_pressed", KEY_pressed, e_pr);
                check("KEY_released", KEY_released, e_rl);
                check("KEY_repeat", KEY_repeat, e_rp);
                check("norpt_SW_deb", b_SW_deb, e_swdeb);
                check("norpt_SW_changed", b_SW_changed, e_swch);
                check("norpt_KEY_down", b_KEY_down, e_dn);
                check("norpt_KEY_pressed", b_KEY_pressed, e_pr);
                check("norpt_KEY_released", b_KEY_released, e_rl);
                check("norpt_KEY_repeat", b_KEY_repeat, e_pr);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n_pr, n_rl, n_rp, t_pr, t_rl, mism;
        int  rp_t [8];
        int  exp_rp [8];
        logic seen;
        exp_rp = '{6, 16, 19, 22, 25, 28, 31, 34};

        // Reset, then release with idle pins: no spurious pulses
        repeat (3) tick();
        rst = 1'b0;
        check("rst_SW_deb", SW_deb, 0);
        check("rst_KEY_down", KEY_down, 0);
        check("rst_pulses", {SW_changed, KEY_pressed, KEY_released, KEY_repeat}, 0);
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            seen |= (|SW_changed) | (|KEY_pressed) | (|KEY_released) | (|KEY_repeat);
        end
        check("post_rst_quiet", seen, 0);

        // 1: SW[0] step, accepted on the 6th edge
        SW[0] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 5) check("t1_SW_deb_e5", SW_deb, 0);
        end
        check("t1_SW_deb_e6", SW_deb, 10'h001);
        check("t1_SW_changed_e6", SW_changed, 10'h001);
        tick();
        check("t1_SW_changed_e7", SW_changed, 0);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        SW[3] = 1'b1;
        seen = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 3) SW[3] = 1'b0;
            seen |= SW_changed[3] | SW_deb[3];
        end
        check("t2_glitch_rejected", seen, 0);
        SW[3] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 4) SW[3] = 1'b0;
            if (t == 5)  check("t2_acc_e5", {SW_deb[3], SW_changed[3]}, 2'b00);
            if (t == 6)  check("t2_acc_e6", {SW_deb[3], SW_changed[3]}, 2'b11);
            if (t == 10) check("t2_fall_e10", {SW_deb[3], SW_changed[3]}, 2'b01);
        end

        // 3: KEY[1] low for 30 cycles, repeat schedule and release latency
        n_pr = 0; n_rl = 0; n_rp = 0; t_pr = -1; t_rl = -1;
        for (int i = 0; i < 8; i++) rp_t[i] = -1;
        KEY[1] = 1'b0;
        for (int t = 1; t <= 42; t++) begin
            tick();
            if (KEY_pressed[1])  begin n_pr++; t_pr = t; end
            if (KEY_released[1]) begin n_rl++; t_rl = t; end
            if (KEY_repeat[1]) begin
                if (n_rp < 8) rp_t[n_rp] = t;
                n_rp++;
            end
            if (t == 30) KEY[1] = 1'b1;
        end
        check("t3_press_count", n_pr, 1);
        check("t3_press_cycle", t_pr, 6);
        check("t3_repeat_count", n_rp, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t3_repeat_%0d", i), rp_t[i], exp_rp[i]);
        check("t3_release_count", n_rl, 1);
        check("t3_release_cycle", t_rl, 36);

        // 4: all keys pressed together
        KEY = 4'h0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 5) check("t4_pressed_e5", KEY_pressed, 4'h0);
        end
        check("t4_pressed_e6", KEY_pressed, 4'hF);
        check("t4_repeat_e6", KEY_repeat, 4'hF);
        tick();
        check("t4_pressed_e7", KEY_pressed, 4'h0);
        check("t4_down_e7", KEY_down, 4'hF);
        KEY = 4'hF;
        repeat (12) tick();
        check("t4_released_idle", KEY_down, 4'h0);

        // 5: reset mid-debounce discards progress
        KEY[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_outputs",
              {SW_deb, SW_changed, KEY_down, KEY_pressed, KEY_released, KEY_repeat}, 0);
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 5) check("t5_pressed_e5", KEY_pressed, 4'h0);
        end
        check("t5_pressed_e6", KEY_pressed, 4'h1);
        check("t5_swdeb_e6", SW_deb, 10'h001);
        KEY[0] = 1'b1;
        repeat (12) tick();

        // 6: REPEAT_EN=0 repeat mirrors pressed
        n_rp = 0; mism = 0;
        KEY[2] = 1'b0;
        for (int t = 1; t <= 42; t++) begin
            tick();
            if (b_KEY_repeat[2] !== b_KEY_pressed[2]) mism++;
            if (b_KEY_repeat[2]) n_rp++;
            if (t == 30) KEY[2] = 1'b1;
        end
        check("t6_norpt_pulses", n_rp, 1);
        check("t6_norpt_mirror", mism, 0);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
